// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma datapath.
// Holds the letter width, alphabet size and largest rotor position, the
// stepper FSM state type, and the default notch positions for the stepper.
package enigma_pkg;

    localparam int LETTER_W = 5;
    localparam int ALPHABET = 26;
    localparam logic [LETTER_W-1:0] POS_MAX = 5'd25;

    localparam int DEFAULT_NOTCH1 = 16;
    localparam int DEFAULT_NOTCH2 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        ISSUE = 2'd2
    } stepper_state_t;

endpackage

// File: rtl/rotor_stepper_if.sv
// Keypress and rotor-offset bundle between a key source and rotor_stepper.
// Ports:
//   key_valid/key_in          keypress strobe and letter code (1..26)
//   load/load_pos1..3         initial rotor position load
//   ready                     stepper idle and able to take a key
//   key_out/key_out_valid     latched letter and its one-cycle strobe
//   rot1..3                   rotor offsets for the substitution stages
// The master modport is the key source; the slave modport is the stepper.
interface rotor_stepper_if;
    import enigma_pkg::*;

    logic                key_valid;
    logic [LETTER_W-1:0] key_in;
    logic                load;
    logic [LETTER_W-1:0] load_pos1;
    logic [LETTER_W-1:0] load_pos2;
    logic [LETTER_W-1:0] load_pos3;
    logic                ready;
    logic [LETTER_W-1:0] key_out;
    logic                key_out_valid;
    logic [LETTER_W-1:0] rot1;
    logic [LETTER_W-1:0] rot2;
    logic [LETTER_W-1:0] rot3;

    modport master (
        output key_valid, key_in, load, load_pos1, load_pos2, load_pos3,
        input  ready, key_out, key_out_valid, rot1, rot2, rot3
    );

    modport slave (
        input  key_valid, key_in, load, load_pos1, load_pos2, load_pos3,
        output ready, key_out, key_out_valid, rot1, rot2, rot3
    );

endinterface

// File: rtl/rotor_position.sv
// One rotor position counter (0..25).
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   step_en    advance the position by one, wrapping 25 -> 0
//   load       overwrite the position with load_val (takes priority)
//   load_val   initial position; 26..31 are folded back to 0..5
//   pos        current position
//   at_notch   position equals the NOTCH parameter
module rotor_position
    import enigma_pkg::*;
#(
    parameter int NOTCH = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_en,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_val,
    output logic [LETTER_W-1:0] pos,
    output logic                at_notch
);

    logic [LETTER_W-1:0] load_reduced;
    logic [LETTER_W-1:0] pos_next;

    // Out-of-range load values are folded into the alphabet by a single
    // subtraction; a 5-bit value can exceed 25 by at most 6.
    always_comb begin
        load_reduced = load_val;
        if (load_val > POS_MAX) begin
            load_reduced = load_val - LETTER_W'(ALPHABET);
        end
    end

    // Explicit wrap compare keeps the increment a plain 5-bit adder.
    always_comb begin
        pos_next = pos + 5'd1;
        if (pos == POS_MAX) begin
            pos_next = '0;
        end
    end

    // Load beats stepping so a load issued mid-step leaves exactly the
    // loaded position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (load) begin
            pos <= load_reduced;
        end else if (step_en) begin
            pos <= pos_next;
        end
    end

    assign at_notch = (pos == LETTER_W'(NOTCH));

endmodule

// File: rtl/rotor_stepper.sv
// Rotor stepping controller feeding the rotor substitution stages.
// Accepts one keypress at a time, advances the three rotor offsets with
// odometer stepping (including the middle-rotor double step) and then
// presents the key with the post-step offsets.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        rotor_stepper_if slave: key in, load, ready, key out, rot1..3
// Parameters:
//   NOTCH1     rotor-1 position that carries rotor 2
//   NOTCH2     rotor-2 position that double-steps rotors 2 and 3
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter int NOTCH1 = DEFAULT_NOTCH1,
    parameter int NOTCH2 = DEFAULT_NOTCH2
) (
    input  logic           clk,
    input  logic           rst,
    rotor_stepper_if.slave bus
);

    stepper_state_t      state;
    stepper_state_t      state_next;
    logic                key_ok;
    logic                accept;
    logic                step;
    logic                notch1;
    logic                notch2;
    logic                unused_notch3;
    logic [LETTER_W-1:0] key_latch;

    // A key is taken only when idle, in range and not colliding with a load.
    assign key_ok = (bus.key_in >= 5'd1) && (bus.key_in <= LETTER_W'(ALPHABET));
    assign accept = bus.key_valid && (state == IDLE) && key_ok && !bus.load;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load forces IDLE from any state, aborting a key.
    always_comb begin
        state_next = state;
        step       = 1'b0;
        if (bus.load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = STEP;
                    end
                end
                STEP: begin
                    step       = 1'b1;
                    state_next = ISSUE;
                end
                ISSUE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Key latch captures the letter at acceptance and holds it for ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_latch <= '0;
        end else if (accept) begin
            key_latch <= bus.key_in;
        end
    end

    assign bus.ready         = (state == IDLE);
    assign bus.key_out       = key_latch;
    assign bus.key_out_valid = (state == ISSUE);

    // Rotor 1 always steps. Rotor 2 steps on rotor-1 carry or on its own
    // notch (the double step); rotor 3 steps only on rotor-2 notch.
    rotor_position #(.NOTCH(NOTCH1)) u_rotor1 (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step),
        .load     (bus.load),
        .load_val (bus.load_pos1),
        .pos      (bus.rot1),
        .at_notch (notch1)
    );

    rotor_position #(.NOTCH(NOTCH2)) u_rotor2 (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step && (notch1 || notch2)),
        .load     (bus.load),
        .load_val (bus.load_pos2),
        .pos      (bus.rot2),
        .at_notch (notch2)
    );

    // Rotor 3 has no successor to carry into, so its notch output is spare.
    rotor_position #(.NOTCH(0)) u_rotor3 (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step && notch2),
        .load     (bus.load),
        .load_val (bus.load_pos3),
        .pos      (bus.rot3),
        .at_notch (unused_notch3)
    );

endmodule

// File: tb/tb_rotor_stepper.sv
// Scoreboard testbench for rotor_stepper: each accepted key pushes the
// hand-computed key/rotor values expected at its strobe; a monitor pops and
// compares whenever key_out_valid is seen.
module tb_rotor_stepper;

    typedef struct {
        logic [4:0] key;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] r3;
    } expect_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    expect_t sbq[$];

    rotor_stepper_if bus ();

    rotor_stepper #(.NOTCH1(16), .NOTCH2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic checkRot(input string name, input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3);
        checkOutput({name, "_rot1"}, bus.rot1, e1);
        checkOutput({name, "_rot2"}, bus.rot2, e2);
        checkOutput({name, "_rot3"}, bus.rot3, e3);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.key_out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_strobe actual=1 required=0 key_out=%0d", bus.key_out);
            end else begin
                expect_t e;
                e = sbq.pop_front();
                checkOutput("strobe_key", bus.key_out, e.key);
                checkOutput("strobe_rot1", bus.rot1, e.r1);
                checkOutput("strobe_rot2", bus.rot2, e.r2);
                checkOutput("strobe_rot3", bus.rot3, e.r3);
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3,
                          input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3);
        @(posedge clk); #1;
        bus.load = 1'b1;
        bus.load_pos1 = p1;
        bus.load_pos2 = p2;
        bus.load_pos3 = p3;
        @(posedge clk); #1;
        bus.load = 1'b0;
        checkRot("load", e1, e2, e3);
        checkOutput("load_ready", {4'b0, bus.ready}, 5'd1);
    endtask

    // Issue one valid key with its expected post-step rotor values.
    task automatic applyStimulus(input logic [4:0] k, input logic [4:0] e1,
                                 input logic [4:0] e2, input logic [4:0] e3);
        expect_t e;
        @(posedge clk); #1;
        bus.key_valid = 1'b1;
        bus.key_in = k;
        e.key = k; e.r1 = e1; e.r2 = e2; e.r3 = e3;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        checkOutput("ready_n1", {4'b0, bus.ready}, 5'd0);
        @(posedge clk); #1;
        checkOutput("ready_n2", {4'b0, bus.ready}, 5'd0);
        @(posedge clk); #1;
        checkOutput("ready_n3", {4'b0, bus.ready}, 5'd1);
        checkOutput("pending", 5'(sbq.size()), 5'd0);
    endtask

    task automatic rejectKey(input logic [4:0] k, input logic [4:0] e1,
                             input logic [4:0] e2, input logic [4:0] e3);
        @(posedge clk); #1;
        bus.key_valid = 1'b1;
        bus.key_in = k;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        checkOutput("reject_ready", {4'b0, bus.ready}, 5'd1);
        idleCycles(3);
        checkRot("reject", e1, e2, e3);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_in = '0;
        bus.load = 1'b0;
        bus.load_pos1 = '0;
        bus.load_pos2 = '0;
        bus.load_pos3 = '0;
        idleCycles(2);
        checkRot("reset", 5'd0, 5'd0, 5'd0);
        checkOutput("reset_ready", {4'b0, bus.ready}, 5'd1);
        checkOutput("reset_key_out", bus.key_out, 5'd0);
        checkOutput("reset_valid", {4'b0, bus.key_out_valid}, 5'd0);
        rst = 1'b0;

        // Basic step, carry, double step, wrap.
        doLoad(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus(5'd1, 5'd1, 5'd0, 5'd0);
        doLoad(5'd16, 5'd0, 5'd0, 5'd16, 5'd0, 5'd0);
        applyStimulus(5'd7, 5'd17, 5'd1, 5'd0);
        doLoad(5'd16, 5'd3, 5'd0, 5'd16, 5'd3, 5'd0);
        applyStimulus(5'd2, 5'd17, 5'd4, 5'd0);
        applyStimulus(5'd3, 5'd18, 5'd5, 5'd1);
        doLoad(5'd25, 5'd25, 5'd25, 5'd25, 5'd25, 5'd25);
        applyStimulus(5'd26, 5'd0, 5'd25, 5'd25);

        // Load reduction, then out-of-range codes.
        doLoad(5'd30, 5'd1, 5'd31, 5'd4, 5'd1, 5'd5);
        rejectKey(5'd0, 5'd4, 5'd1, 5'd5);
        rejectKey(5'd27, 5'd4, 5'd1, 5'd5);

        // Second key during STEP is ignored.
        begin
            expect_t e;
            @(posedge clk); #1;
            bus.key_valid = 1'b1;
            bus.key_in = 5'd4;
            e.key = 5'd4; e.r1 = 5'd5; e.r2 = 5'd1; e.r3 = 5'd5;
            sbq.push_back(e);
            @(posedge clk); #1;
            bus.key_in = 5'd9;
            @(posedge clk); #1;
            bus.key_valid = 1'b0;
            idleCycles(3);
            checkRot("ignored_second", 5'd5, 5'd1, 5'd5);
            checkOutput("ignored_pending", 5'(sbq.size()), 5'd0);
        end

        // Load together with key_valid: load wins, no strobe.
        @(posedge clk); #1;
        bus.load = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_in = 5'd3;
        bus.load_pos1 = 5'd2; bus.load_pos2 = 5'd3; bus.load_pos3 = 5'd4;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.key_valid = 1'b0;
        checkOutput("loadkey_ready", {4'b0, bus.ready}, 5'd1);
        idleCycles(3);
        checkRot("loadkey", 5'd2, 5'd3, 5'd4);

        // Load during STEP aborts the key.
        @(posedge clk); #1;
        bus.key_valid = 1'b1;
        bus.key_in = 5'd8;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        bus.load = 1'b1;
        bus.load_pos1 = 5'd5; bus.load_pos2 = 5'd6; bus.load_pos3 = 5'd7;
        @(posedge clk); #1;
        bus.load = 1'b0;
        checkOutput("abort_ready", {4'b0, bus.ready}, 5'd1);
        checkRot("abort", 5'd5, 5'd6, 5'd7);
        idleCycles(3);
        applyStimulus(5'd9, 5'd6, 5'd6, 5'd7);

        // Reset during STEP aborts immediately.
        @(posedge clk); #1;
        bus.key_valid = 1'b1;
        bus.key_in = 5'd11;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkRot("midreset", 5'd0, 5'd0, 5'd0);
        checkOutput("midreset_ready", {4'b0, bus.ready}, 5'd1);
        idleCycles(2);
        rst = 1'b0;
        idleCycles(3);
        checkOutput("final_pending", 5'(sbq.size()), 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Rotor stepping controller for the Enigma datapath. Sits directly upstream of the rotor substitution stages. It accepts one validated keypress at a time and advances the three rotor offsets with odometer stepping, including the middle-rotor double step. It then presents the key with the updated `rotate` offsets, so the rotor stages always encrypt with post-step positions, as a real Enigma does.

## Interface
Parameters:
- `NOTCH1`, default 16: rotor-1 position (0..25) at which rotor 2 is carried.
- `NOTCH2`, default 4: rotor-2 position (0..25) at which rotors 2 and 3 step (double step).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle keypress strobe.
- `key_in`  in  5  letter code, 1..26; 0 and 27..31 are invalid.
- `load`  in  1  load initial rotor positions.
- `load_pos1`, `load_pos2`, `load_pos3`  in  5 each  initial positions.
- `ready`  out  1  high when idle and able to accept a key.
- `key_out`  out  5  latched letter for the rotor stages.
- `key_out_valid`  out  1  one-cycle strobe; `key_out` and `rot*` are valid.
- `rot1`, `rot2`, `rot3`  out  5 each  rotor offsets (0..25), fed to each rotor's `rotate`.

## Operation
- FSM states:
  - IDLE -> STEP on an accepted key.
  - STEP -> ISSUE unconditionally.
  - ISSUE -> IDLE unconditionally.
- `ready` = (state == IDLE), combinational.
- Key acceptance: `key_valid` && IDLE && 1 <= `key_in` <= 26 && !`load`. On acceptance, `key_in` is latched into `key_out`.
- Invalid codes are dropped: no step, no strobe. `key_valid` outside IDLE is ignored; it is not queued.
- STEP evaluates the pre-step positions p1, p2:
  - rotor 1 always steps.
  - rotor 2 steps if p1 == NOTCH1 or p2 == NOTCH2.
  - rotor 3 steps if p2 == NOTCH2.
- Stepping is +1 with wrap 25 -> 0. Arithmetic is 5-bit; comparisons with 25 are explicit, with no modulo operator.
- ISSUE: `key_out_valid` = 1 for exactly one cycle.
- `load` has priority in every state:
  - positions are set from `load_pos*`; values 26..31 are reduced by 26 (to 0..5);
  - the FSM goes to IDLE and any in-flight key is aborted with no strobe;
  - `load` and `key_valid` in the same cycle: load wins and the key is dropped.
- `rot*` are registered and change only at the STEP edge, a load edge, or reset.

## Timing
- Reset values:
  - `rot1`, `rot2`, `rot3` = 0; `key_out` = 0; `key_out_valid` = 0; state = IDLE, so `ready` = 1.
- Reset mid-operation aborts immediately, with no strobe.
- Key accepted in cycle N:
  - N+1: state STEP, `ready` = 0.
  - End of N+1: positions update.
  - N+2: `key_out_valid` = 1, with new `rot*` visible.
  - N+3: `ready` = 1.
- Throughput: one key per 3 cycles.
- Load asserted in cycle N: new positions visible in N+1, `ready` = 1 in N+1.

## Structure
- Shared package `enigma_pkg` holds:
  - `LETTER_W` = 5, `ALPHABET` = 26, `POS_MAX` = 25;
  - the stepper state enum (IDLE, STEP, ISSUE);
  - the default notch constants.
- Sub-module `rotor_position`, instantiated three times:
  - inputs: `clk`, `rst`, `step_en`, `load`, `load_val`;
  - outputs: `pos` and `at_notch` (NOTCH parameter).
  - it contains the wrap counter and load reduction.
- The top level holds the FSM, the key latch and the carry logic.

## Test plan
- Reset: assert `rst` mid-STEP -> `rot*` = 0/0/0, `ready` = 1, `key_out_valid` never pulses.
- Load (0,0,0), key 1 at cycle N -> in N+2 `key_out_valid` = 1, `key_out` = 1, `rot*` = (1,0,0); `ready` low in N+1..N+2.
- Carry: load (16,0,0), any key -> (17,1,0).
- Double step: load (16,3,0), two keys -> (17,4,0), then (18,5,1).
- Wrap and load reduction:
  - load (25,25,25), key -> (0,25,25);
  - load_pos1 = 30 -> `rot1` = 4.
- Rejection:
  - `key_in` = 0 or 27 -> no strobe, `rot*` unchanged;
  - second `key_valid` during STEP -> ignored;
  - `load` with `key_valid` -> load applied, no strobe;
  - `load` during STEP -> abort, no strobe.
